bloom_inserter: RTL
===================

BLOOM_INSERTER -- requirements
Module: bloom_inserter

Interface
REQ-001 SHALL have parameter D_SIZE, default 32; width of the inserted data item, 1..32.
REQ-002 SHALL have parameter BL_SIZE, default 64; bloom vector length, a power of two, 2..4096.
REQ-003 SHALL have parameter K_HASH, default 3; hash functions per item, 1..4.
REQ-004 SHALL have parameter CNT_W, default 16; width of the item counter.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  in  1  item offered.
REQ-008 SHALL have port in_ready  out  1  item can be accepted.
REQ-009 SHALL have port in_data  in  D_SIZE  item to insert.
REQ-010 SHALL have port clear  in  1  synchronous filter wipe.
REQ-011 SHALL have port bloom  out  BL_SIZE  registered filter vector.
REQ-012 SHALL have port item_mask  out  BL_SIZE  one-hot OR of the last item's indices; same format as the query-side hash mask.
REQ-013 SHALL have port mask_valid  out  1  one-cycle pulse when an insertion completes.
REQ-014 SHALL have port dup  out  1  with mask_valid: the item set no new bit.
REQ-015 SHALL have port count  out  CNT_W  items inserted since reset/clear, saturating.
REQ-016 SHALL have port full  out  1  count == 2^CNT_W-1.
REQ-017 SHALL have port ones  out  log2(BL_SIZE)+1  number of set bits in bloom.

Function
REQ-018 SHALL implement FSM states IDLE, HASH, DONE.
REQ-019 SHALL drive in_ready = (state==IDLE) && !clear.
REQ-020 SHALL capture in_data, zero-extended to 32 bits, on in_valid && in_ready, clear item_mask, set j=0, and go IDLE->HASH.
REQ-021 SHALL ignore in_valid in HASH and DONE; no queuing.
REQ-022 SHALL compute idx_j = bits [31 -: log2(BL_SIZE)] of (data * M_j) mod 2^32, with M_0=32'h9E3779B1, M_1=32'h85EBCA77, M_2=32'hC2B2AE3D, M_3=32'h27D4EB2F.
REQ-023 SHALL, in HASH cycle j, set bloom[idx_j] and item_mask[idx_j] at the clock edge.
REQ-024 SHALL increment ones and set an internal new_bit flag only if bloom[idx_j] was 0 before that edge; repeated indices SHALL NOT double-count.
REQ-025 SHALL take the HASH->DONE transition after j=K_HASH-1; DONE->IDLE is unconditional.
REQ-026 SHALL, in DONE, assert mask_valid for exactly one cycle, drive dup = !new_bit, and increment count unless full.
REQ-027 SHALL hold count at 2^CNT_W-1 once saturated; full stays 1 until clear or rst.
REQ-028 SHALL give latency from accept edge to mask_valid of K_HASH+1 cycles, and one item per K_HASH+2 cycles throughput.
REQ-029 SHALL give clear priority in any state: next edge zeroes bloom, item_mask, count and ones, deasserts mask_valid, aborts any insertion without a mask_valid pulse, and returns to IDLE.
REQ-030 SHALL hold bloom, item_mask, count and ones stable in IDLE absent clear.
REQ-031 SHALL keep dup meaningful only while mask_valid=1; otherwise dup=0.

Reset
REQ-032 SHALL, on rst asserted, immediately force state=IDLE, bloom=0, item_mask=0, mask_valid=0, dup=0, count=0, ones=0 and full=0, independent of clk.
REQ-033 SHALL abandon any insertion in progress at reset with no mask_valid; in_ready SHALL be 1 after rst deasserts, provided clear=0.

Verification
REQ-034 SHALL cover: BL_SIZE=64, K_HASH=3, insert 1 -> mask_valid 4 cycles after accept, bloom bits 39,33,48 set, ones=3, count=1, dup=0.
REQ-035 SHALL cover: insert 0 twice -> bloom=1, ones=1, first dup=0, second dup=1, count=2.
REQ-036 SHALL cover: in_valid held high continuously -> accepts exactly every 5 cycles, in_ready=0 in HASH and DONE.
REQ-037 SHALL cover: clear asserted in the 2nd HASH cycle -> next edge bloom=0, count=0, ones=0, no mask_valid, in_ready=1.
REQ-038 SHALL cover: CNT_W=2, 4 distinct inserts -> count 1,2,3,3, full=1 after the 3rd.
REQ-039 SHALL cover: rst pulsed mid-clock during HASH -> outputs zero before the next edge, no mask_valid afterwards.

Source files
------------

// File: rtl/bloom_inserter.sv
// Bloom filter inserter: hashes one item per K_HASH+2 cycles into a bit vector,
// reporting the item's index mask, duplicate status, item count and population.
module bloom_inserter #(
   parameter int D_SIZE  = 32,
   parameter int BL_SIZE = 64,
   parameter int K_HASH  = 3,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [D_SIZE-1:0]          in_data,
   input  logic                       clear,
   output logic [BL_SIZE-1:0]         bloom,
   output logic [BL_SIZE-1:0]         item_mask,
   output logic                       mask_valid,
   output logic                       dup,
   output logic [CNT_W-1:0]           count,
   output logic                       full,
   output logic [$clog2(BL_SIZE):0]   ones
);

   localparam int IDX_W = $clog2(BL_SIZE);

   typedef enum logic [1:0] {IDLE, HASH, DONE} state_t;

   state_t               state_reg;
   logic [31:0]          data_reg;
   logic [1:0]           j_reg;
   logic                 new_bit_reg;
   logic [BL_SIZE-1:0]   bloom_reg;
   logic [BL_SIZE-1:0]   item_mask_reg;
   logic                 mask_valid_reg;
   logic                 dup_reg;
   logic [CNT_W-1:0]     count_reg;
   logic [IDX_W:0]       ones_reg;

   logic [IDX_W-1:0]     hash_idx [4];
   logic [IDX_W-1:0]     cur_idx;

   function automatic logic [31:0] mult_const(input int n);
      case (n)
         0:       return 32'h9E3779B1;
         1:       return 32'h85EBCA77;
         2:       return 32'hC2B2AE3D;
         default: return 32'h27D4EB2F;
      endcase
   endfunction

   // Multiplicative hashes; the index is the top IDX_W bits of the 32-bit product.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_hash
         if (gi < K_HASH) begin : g_on
            assign hash_idx[gi] = IDX_W'((data_reg * mult_const(gi)) >> (32 - IDX_W));
         end else begin : g_off
            assign hash_idx[gi] = '0;
         end
      end
   endgenerate

   assign cur_idx = hash_idx[j_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         data_reg       <= '0;
         j_reg          <= '0;
         new_bit_reg    <= 1'b0;
         bloom_reg      <= '0;
         item_mask_reg  <= '0;
         mask_valid_reg <= 1'b0;
         dup_reg        <= 1'b0;
         count_reg      <= '0;
         ones_reg       <= '0;
      end else if (clear) begin
         state_reg      <= IDLE;
         j_reg          <= '0;
         new_bit_reg    <= 1'b0;
         bloom_reg      <= '0;
         item_mask_reg  <= '0;
         mask_valid_reg <= 1'b0;
         dup_reg        <= 1'b0;
         count_reg      <= '0;
         ones_reg       <= '0;
      end else begin
         mask_valid_reg <= 1'b0;
         dup_reg        <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg      <= 32'(in_data);
                  item_mask_reg <= '0;
                  j_reg         <= '0;
                  new_bit_reg   <= 1'b0;
                  state_reg     <= HASH;
               end
            end
            HASH: begin
               bloom_reg[cur_idx]     <= 1'b1;
               item_mask_reg[cur_idx] <= 1'b1;
               // An index already set (by an earlier item or hash) adds nothing.
               if (!bloom_reg[cur_idx]) begin
                  ones_reg    <= ones_reg + (IDX_W+1)'(1);
                  new_bit_reg <= 1'b1;
               end
               if (j_reg == 2'(K_HASH - 1)) begin
                  state_reg <= DONE;
               end else begin
                  j_reg <= j_reg + 2'd1;
               end
            end
            DONE: begin
               mask_valid_reg <= 1'b1;
               dup_reg        <= !new_bit_reg;
               if (!full) begin
                  count_reg <= count_reg + CNT_W'(1);
               end
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state_reg == IDLE) && !clear;
   assign bloom      = bloom_reg;
   assign item_mask  = item_mask_reg;
   assign mask_valid = mask_valid_reg;
   assign dup        = dup_reg;
   assign count      = count_reg;
   assign full       = &count_reg;
   assign ones       = ones_reg;

endmodule
